// File: rtl/cu_pkg.sv
// Shared opcode, function, ALU and status encodings for the APB sequencing control unit.
package cu_pkg;

    localparam logic [3:0] OP_REG    = 4'b0000;
    localparam logic [3:0] OP_ADDI   = 4'b0100;
    localparam logic [3:0] OP_LW     = 4'b1011;
    localparam logic [3:0] OP_SW     = 4'b1111;
    localparam logic [3:0] OP_BEQ    = 4'b1000;
    localparam logic [3:0] OP_JMP    = 4'b0010;
    localparam logic [3:0] OP_APB_RD = 4'b1100;
    localparam logic [3:0] OP_APB_WR = 4'b0001;

    localparam logic [2:0] FN_ADD = 3'b000;
    localparam logic [2:0] FN_SUB = 3'b001;
    localparam logic [2:0] FN_AND = 3'b010;
    localparam logic [2:0] FN_OR  = 3'b011;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_ADDI = 3'b100;
    localparam logic [2:0] ALU_LW   = 3'b101;
    localparam logic [2:0] ALU_SW   = 3'b110;
    localparam logic [2:0] ALU_BEQ  = 3'b111;

    localparam logic RB_OR_MEM_OUT = 1'b0;
    localparam logic IMM_OR_ALUOUT = 1'b1;

    localparam logic [1:0] APB_ST_OK      = 2'b00;
    localparam logic [1:0] APB_ST_SLVERR  = 2'b01;
    localparam logic [1:0] APB_ST_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {IDLE, START, WAIT, WB} cu_state_t;

endpackage

// File: rtl/cu_decode.sv
// Single-cycle opcode/func to control-word decode; also flags APB opcodes for the sequencer.
module cu_decode
    import cu_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int FUNC_W   = 3,
    parameter int ALUFN_W  = 3
) (
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNC_W-1:0]   func,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alusrc,
    output logic [ALUFN_W-1:0]  alufn,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                nia,
    output logic                illegal_op,
    output logic                apb_req,
    output logic                apb_wr
);

    always_comb begin
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alusrc     = RB_OR_MEM_OUT;
        alufn      = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        nia        = 1'b1;
        illegal_op = 1'b0;
        apb_req    = 1'b0;
        apb_wr     = 1'b0;
        if (instr_valid) begin
            case (opcode)
                OPCODE_W'(OP_REG): begin
                    reg_dst    = 1'b1;
                    reg_write  = 1'b1;
                    mem_to_reg = IMM_OR_ALUOUT;
                    case (func)
                        FUNC_W'(FN_ADD): alufn = ALUFN_W'(ALU_ADD);
                        FUNC_W'(FN_SUB): alufn = ALUFN_W'(ALU_SUB);
                        FUNC_W'(FN_AND): alufn = ALUFN_W'(ALU_AND);
                        FUNC_W'(FN_OR):  alufn = ALUFN_W'(ALU_OR);
                        default: begin
                            // Undefined func must not leave any write enable asserted
                            reg_dst    = 1'b0;
                            reg_write  = 1'b0;
                            mem_to_reg = 1'b0;
                            illegal_op = 1'b1;
                        end
                    endcase
                end
                OPCODE_W'(OP_ADDI): begin
                    alufn      = ALUFN_W'(ALU_ADDI);
                    alusrc     = IMM_OR_ALUOUT;
                    reg_write  = 1'b1;
                    mem_to_reg = IMM_OR_ALUOUT;
                end
                OPCODE_W'(OP_LW): begin
                    alufn      = ALUFN_W'(ALU_LW);
                    alusrc     = IMM_OR_ALUOUT;
                    mem_read   = 1'b1;
                    reg_write  = 1'b1;
                    mem_to_reg = RB_OR_MEM_OUT;
                end
                OPCODE_W'(OP_SW): begin
                    alufn     = ALUFN_W'(ALU_SW);
                    alusrc    = IMM_OR_ALUOUT;
                    mem_write = 1'b1;
                end
                OPCODE_W'(OP_BEQ):    alufn   = ALUFN_W'(ALU_BEQ);
                OPCODE_W'(OP_JMP):    nia     = 1'b0;
                OPCODE_W'(OP_APB_RD): apb_req = 1'b1;
                OPCODE_W'(OP_APB_WR): begin
                    apb_req = 1'b1;
                    apb_wr  = 1'b1;
                end
                default: illegal_op = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/apb_seq_control_unit.sv
// Control unit: combinational decode for ordinary opcodes, FSM sequencing for APB transfers.
module apb_seq_control_unit
    import cu_pkg::*;
#(
    parameter int OPCODE_W       = 4,
    parameter int FUNC_W         = 3,
    parameter int ALUFN_W        = 3,
    parameter int APB_SEL_W      = 2,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [FUNC_W-1:0]    func,
    input  logic                 ready,
    input  logic                 apb_err,
    output logic                 reg_dst,
    output logic                 reg_write,
    output logic                 alusrc,
    output logic [ALUFN_W-1:0]   alufn,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 apb_op,
    output logic                 apb_write,
    output logic [APB_SEL_W-1:0] apb_sel,
    output logic                 start_flag,
    output logic                 continue_flag,
    output logic                 nia,
    output logic [1:0]           apb_status,
    output logic                 illegal_op
);

    cu_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 apb_write_q;
    logic [APB_SEL_W-1:0] apb_sel_q;
    logic [1:0]           status_q;

    logic                 dec_reg_dst, dec_reg_write, dec_alusrc;
    logic [ALUFN_W-1:0]   dec_alufn;
    logic                 dec_mem_read, dec_mem_write, dec_mem_to_reg;
    logic                 dec_nia, dec_illegal, dec_apb_req, dec_apb_wr;
    logic                 timeout;

    cu_decode #(
        .OPCODE_W (OPCODE_W),
        .FUNC_W   (FUNC_W),
        .ALUFN_W  (ALUFN_W)
    ) u_decode (
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .func        (func),
        .reg_dst     (dec_reg_dst),
        .reg_write   (dec_reg_write),
        .alusrc      (dec_alusrc),
        .alufn       (dec_alufn),
        .mem_read    (dec_mem_read),
        .mem_write   (dec_mem_write),
        .mem_to_reg  (dec_mem_to_reg),
        .nia         (dec_nia),
        .illegal_op  (dec_illegal),
        .apb_req     (dec_apb_req),
        .apb_wr      (dec_apb_wr)
    );

    assign timeout   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign apb_write = apb_write_q;
    assign apb_sel   = apb_sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            apb_write_q <= 1'b0;
            apb_sel_q   <= '0;
            status_q    <= APB_ST_OK;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (dec_apb_req) begin
                    apb_write_q <= dec_apb_wr;
                    apb_sel_q   <= func[APB_SEL_W-1:0];
                end
                START: cnt_q <= '0;
                WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (ready)
                        status_q <= apb_err ? APB_ST_SLVERR : APB_ST_OK;
                    else if (timeout)
                        status_q <= APB_ST_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alusrc        = RB_OR_MEM_OUT;
        alufn         = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        apb_op        = 1'b0;
        start_flag    = 1'b0;
        continue_flag = 1'b1;
        nia           = 1'b1;
        apb_status    = APB_ST_OK;
        illegal_op    = 1'b0;
        case (state_q)
            IDLE: begin
                reg_dst       = dec_reg_dst;
                reg_write     = dec_reg_write;
                alusrc        = dec_alusrc;
                alufn         = dec_alufn;
                mem_read      = dec_mem_read;
                mem_write     = dec_mem_write;
                mem_to_reg    = dec_mem_to_reg;
                nia           = dec_nia;
                illegal_op    = dec_illegal;
                continue_flag = ~dec_apb_req;
                if (dec_apb_req)
                    state_d = START;
            end
            START: begin
                start_flag    = 1'b1;
                apb_op        = 1'b1;
                continue_flag = 1'b0;
                state_d       = WAIT;
            end
            WAIT: begin
                apb_op        = 1'b1;
                continue_flag = 1'b0;
                if (ready || timeout)
                    state_d = WB;
            end
            WB: begin
                // Only a clean read returns data to the register file
                apb_status = status_q;
                reg_write  = ~apb_write_q && (status_q == APB_ST_OK);
                mem_to_reg = ~apb_write_q && (status_q == APB_ST_OK);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/apb_seq_control_unit.md
Name: apb_seq_control_unit

Overview:
- Parametrised, multi-cycle successor to the single-cycle instruction decoder.
- Decodes register, immediate, memory and branch/jump opcodes combinationally, in one cycle.
- Sequences APB read/write opcodes with a registered FSM: start pulse, ready handshake, timeout, writeback.
- Sits between the instruction register and the datapath muxes, ALU and APB master. continue_flag stalls the PC while an APB transfer is in flight.

Parameters:
- OPCODE_W, 4, opcode field width.
- FUNC_W, 3, function field width.
- ALUFN_W, 3, ALU function select width.
- APB_SEL_W, 2, APB slave-select width, taken from func[APB_SEL_W-1:0]; must be <= FUNC_W.
- TIMEOUT_CYCLES, 256, maximum WAIT cycles before the transfer is abandoned; must be >= 2.
- CNT_W, $clog2(TIMEOUT_CYCLES), timeout counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  opcode/func are valid this cycle.
- opcode  in  OPCODE_W  instruction opcode.
- func  in  FUNC_W  function field.
- ready  in  1  APB master transfer complete.
- apb_err  in  1  slave error, sampled together with ready.
- reg_dst  out  1  1 = rd, 0 = rt.
- reg_write  out  1  register file write enable.
- alusrc  out  1  0 = rb/mem_out, 1 = imm.
- alufn  out  ALUFN_W  ALU operation.
- mem_read  out  1  data memory read.
- mem_write  out  1  data memory write.
- mem_to_reg  out  1  1 = ALU/APB result, 0 = memory data.
- apb_op  out  1  APB transfer active.
- apb_write  out  1  1 = APB write, 0 = APB read.
- apb_sel  out  APB_SEL_W  latched slave select.
- start_flag  out  1  one-cycle APB start pulse.
- continue_flag  out  1  1 = PC may advance.
- nia  out  1  1 = next sequential address, 0 = jump target.
- apb_status  out  2  00 ok, 01 slave error, 10 timeout; valid while continue_flag=1 in WB.
- illegal_op  out  1  unrecognised opcode/func.

Behaviour:
- Reset:
  - State IDLE, counter 0, apb_sel 0.
  - All outputs 0 except continue_flag=1 and nia=1.
  - Reset mid-transfer aborts immediately: no writeback, no start_flag.
- Every output is assigned a default in every state and opcode path. No latches, no combinational loops.
- IDLE, instr_valid=1, non-APB opcodes (combinational, same cycle):
  - REG (0000): func ADD/SUB/AND/OR gives alufn 000/001/010/011, reg_dst=1, reg_write=1, mem_to_reg=1.
  - ADDI (0100): alufn=100, alusrc=1, reg_write=1, mem_to_reg=1.
  - LW (1011): alufn=101, alusrc=1, mem_read=1, reg_write=1, mem_to_reg=0.
  - SW (1111): alufn=110, alusrc=1, mem_write=1.
  - BEQ (1000): alufn=111.
  - JMP (0010): nia=0.
- Any other opcode, or REG with an undefined func: all write enables 0, illegal_op=1, continue_flag=1, nia=1.
- instr_valid=0: defaults only.
- APB_RD (1100) / APB_WR (0001) in IDLE with instr_valid=1:
  - Same cycle: continue_flag=0.
  - Clock edge: latch apb_write (1 for APB_WR), latch apb_sel=func[APB_SEL_W-1:0], go to START.
- START, exactly one cycle:
  - start_flag=1, apb_op=1, continue_flag=0, counter cleared.
  - ready is ignored in this state.
  - Next state WAIT.
- WAIT:
  - apb_op=1, continue_flag=0, counter increments.
  - ready=1: go to WB with status = apb_err ? 01 : 00.
  - Counter == TIMEOUT_CYCLES-1 with ready=0: go to WB with status 10.
  - ready has priority over timeout in the same cycle.
- WB, one cycle:
  - continue_flag=1, nia=1, apb_op=0.
  - reg_write=1 and mem_to_reg=1 only for APB_RD with status 00. APB_WR never writes a register.
  - Next state IDLE. A new instruction is accepted in the following cycle.
- Latency: minimum APB instruction is 4 cycles (IDLE, START, WAIT with ready, WB). continue_flag is low for 3 of them.
- opcode/func changes while in START/WAIT/WB are ignored; the latched values govern the transfer.

Decomposition:
- Package cu_pkg holds:
  - opcode and func localparams;
  - ALU op codes;
  - the mux constants RB_OR_MEM_OUT=0 and IMM_OR_ALUOUT=1;
  - apb_status encodings;
  - typedef enum logic [1:0] {IDLE, START, WAIT, WB} cu_state_t.
- One sub-module, cu_decode: purely combinational opcode/func to control-word decode, reused in IDLE.
- The top level holds the FSM, timeout counter and output override logic.

Test Plan:
- ADD (0000/000) then LW (1011): alufn=000, reg_dst=1, reg_write=1; then alufn=101, mem_read=1, mem_to_reg=0; continue_flag stays 1 throughout.
- APB_RD, func=010, ready asserted on the 3rd WAIT cycle: start_flag high exactly 1 cycle, apb_sel=2, apb_write=0, continue_flag low 5 cycles, WB reg_write=1, status 00.
- APB_WR with ready and apb_err=1 on the 1st WAIT cycle: WB has status 01, reg_write=0, apb_write=1; back in IDLE after 4 cycles total.
- TIMEOUT_CYCLES=8, APB_RD, ready never asserted: WB after 8 WAIT cycles, status 10, reg_write=0; next instruction decodes normally.
- rst pulsed in the 2nd WAIT cycle: next cycle is IDLE with apb_op=0, continue_flag=1, and no reg_write or start_flag.
- Opcode 0111, then REG with func 111: illegal_op=1, all write enables 0, continue_flag=1, nia=1.
